pps_source_ctrl: RTL and testbench

Sequences PPS source selection and second-counter loading for the PUEO time core, in the sysclk domain. It qualifies the external PPS by measuring the period between edges, switches the time core between internal and external PPS, and falls back to internal (holdover) when the external PPS is lost. It also schedules software second-loads so they land one cycle after a PPS flag.

---
 rtl/pueo_time_pkg.sv | 20 ++
 rtl/pps_period_checker.sv | 76 +++++++
 rtl/pps_source_ctrl.sv | 152 +++++++++++++++
 tb/tb_pps_source_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_time_pkg.sv
// Shared types for the PUEO time core: PPS controller states, verdict flags
// and the nominal PPS period.
package pueo_time_pkg;

    typedef enum logic [1:0] {
        ST_INT      = 2'd0,
        ST_QUAL     = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } pps_ctrl_state_t;

    localparam logic [31:0] PPS_NOM_PERIOD_DEFAULT = 32'd125000000;

    typedef struct packed {
        logic good;
        logic bad;
        logic miss;
    } pps_verdict_t;

endpackage

// File: rtl/pps_period_checker.sv
// External PPS period checker: counts sysclk cycles between edges and issues
// a registered good/bad/miss verdict. Last-period capture under PPS_SOURCE_CTRL_STATS_EN.
module pps_period_checker
    import pueo_time_pkg::*;
#(
    parameter logic [31:0] NOM_PERIOD = PPS_NOM_PERIOD_DEFAULT
) (
    input  logic         sys_clk_i,
    input  logic         sys_rst_n_i,
    input  logic         ctrl_en_i,
    input  logic         ext_edge_i,
    input  logic [15:0]  tol_i,
    output pps_verdict_t verdict_o,
    output logic [31:0]  last_period_o
);

    logic [31:0] cnt;
    logic        armed;
    logic [32:0] period_w;
    logic [32:0] diff_w;
    logic [32:0] limit_w;
    logic        in_tol;
    logic        period_valid;
    logic        miss_hit;

    always_comb begin
        period_w     = {1'b0, cnt} + 33'd1;
        diff_w       = (period_w >= {1'b0, NOM_PERIOD}) ? (period_w - {1'b0, NOM_PERIOD})
                                                        : ({1'b0, NOM_PERIOD} - period_w);
        limit_w      = {1'b0, NOM_PERIOD} + {17'd0, tol_i} + 33'd1;
        in_tol       = (diff_w <= {17'd0, tol_i});
        period_valid = ctrl_en_i && armed && ext_edge_i;
        // edge wins over miss; miss only fires once because it disarms
        miss_hit     = ctrl_en_i && armed && !ext_edge_i && (period_w >= limit_w);
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            cnt       <= '0;
            armed     <= 1'b0;
            verdict_o <= '0;
        end else begin
            if (ext_edge_i)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 32'd1;

            if (!ctrl_en_i)
                armed <= 1'b0;
            else if (ext_edge_i)
                armed <= 1'b1;
            else if (miss_hit)
                armed <= 1'b0;

            verdict_o.good <= period_valid && in_tol;
            verdict_o.bad  <= period_valid && !in_tol;
            verdict_o.miss <= miss_hit;
        end
    end

`ifdef PPS_SOURCE_CTRL_STATS_EN
    logic [31:0] last_period_q;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i)
            last_period_q <= '0;
        else if (period_valid)
            last_period_q <= period_w[32] ? '1 : period_w[31:0];
    end

    assign last_period_o = last_period_q;
`else
    assign last_period_o = '0;
`endif

endmodule

// File: rtl/pps_source_ctrl.sv
// PPS source sequencer: qualifies external PPS, selects int/ext PPS with holdover,
// and schedules second-loads after a PPS flag. Statistics under PPS_SOURCE_CTRL_STATS_EN.
module pps_source_ctrl
    import pueo_time_pkg::*;
#(
    parameter logic [31:0] NOM_PERIOD = PPS_NOM_PERIOD_DEFAULT,
    parameter              SYSCLKTYPE = "NONE"
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        ctrl_en_i,
    input  logic        ext_edge_i,
    input  logic        pps_flag_i,
    input  logic [15:0] tol_i,
    input  logic [3:0]  qual_count_i,
    input  logic        sec_load_req_i,
    input  logic [31:0] sec_load_val_i,
    output logic        use_ext_pps_o,
    output logic        en_int_pps_o,
    output logic        load_sec_o,
    output logic [31:0] update_sec_o,
    output logic        sec_load_busy_o,
    output logic [1:0]  state_o,
    output logic [7:0]  lost_count_o,
    output logic [31:0] last_period_o
);

    pps_verdict_t    verdict;
    pps_ctrl_state_t state_q, state_d;
    logic [3:0]      good_run_q, good_run_d;
    logic [3:0]      qual_need;

    (* CUSTOM_CC_SRC = SYSCLKTYPE *) logic use_ext_q;
    (* CUSTOM_CC_SRC = SYSCLKTYPE *) logic en_int_q;

    pps_period_checker #(
        .NOM_PERIOD(NOM_PERIOD)
    ) u_checker (
        .sys_clk_i    (sys_clk_i),
        .sys_rst_n_i  (sys_rst_n_i),
        .ctrl_en_i    (ctrl_en_i),
        .ext_edge_i   (ext_edge_i),
        .tol_i        (tol_i),
        .verdict_o    (verdict),
        .last_period_o(last_period_o)
    );

    assign qual_need = (qual_count_i == 4'd0) ? 4'd1 : qual_count_i;

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        if (!ctrl_en_i) begin
            state_d    = ST_INT;
            good_run_d = '0;
        end else begin
            case (state_q)
                ST_INT: begin
                    state_d    = ST_QUAL;
                    good_run_d = '0;
                end
                ST_QUAL, ST_HOLDOVER: begin
                    if (verdict.good) begin
                        if (({1'b0, good_run_q} + 5'd1) >= {1'b0, qual_need}) begin
                            state_d    = ST_LOCKED;
                            good_run_d = '0;
                        end else begin
                            good_run_d = good_run_q + 4'd1;
                        end
                    end else if (verdict.bad || verdict.miss) begin
                        good_run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (verdict.bad || verdict.miss) begin
                        state_d    = ST_HOLDOVER;
                        good_run_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_INT;
                    good_run_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q    <= ST_INT;
            good_run_q <= '0;
            use_ext_q  <= 1'b0;
            en_int_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_run_q <= good_run_d;
            use_ext_q  <= (state_q == ST_LOCKED);
            en_int_q   <= 1'b1;
        end
    end

    assign state_o       = state_q;
    assign use_ext_pps_o = use_ext_q;
    assign en_int_pps_o  = en_int_q;

`ifdef PPS_SOURCE_CTRL_STATS_EN
    logic       lost_evt;
    logic [7:0] lost_q;

    assign lost_evt = (state_q == ST_LOCKED) && (state_d == ST_HOLDOVER);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i)
            lost_q <= '0;
        else if (lost_evt && (lost_q != '1))
            lost_q <= lost_q + 8'd1;
    end

    assign lost_count_o = lost_q;
`else
    assign lost_count_o = '0;
`endif

    logic        busy_q;
    logic        load_q;
    logic [31:0] upd_q;
    logic        fire;

    // busy stays up through the strobe cycle, so mask it there to avoid a re-fire
    assign fire = pps_flag_i && ((busy_q && !load_q) || sec_load_req_i);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            busy_q <= 1'b0;
            load_q <= 1'b0;
            upd_q  <= '0;
        end else begin
            load_q <= fire;
            if (sec_load_req_i)
                upd_q <= sec_load_val_i;
            if (sec_load_req_i)
                busy_q <= 1'b1;
            else if (load_q)
                busy_q <= 1'b0;
        end
    end

    assign load_sec_o      = load_q;
    assign update_sec_o    = upd_q;
    assign sec_load_busy_o = busy_q;

endmodule

// File: tb/tb_pps_source_ctrl.sv
// Scoreboard bench for pps_source_ctrl: an event-level reference model queues
// expected output changes, a negedge monitor pops and compares them.
module tb_pps_source_ctrl;

    localparam int unsigned NOM  = 1000;
    localparam int unsigned TOL  = 5;
    localparam int unsigned QUAL = 3;
`ifdef PPS_SOURCE_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_en = 1'b1;
    logic        ext_edge = 1'b0;
    logic        pps_flag = 1'b0;
    logic        req = 1'b0;
    logic [31:0] val = '0;
    logic [15:0] tol = 16'd5;
    logic [3:0]  qual = 4'd3;

    logic        use_ext, en_int, load_sec, busy;
    logic [31:0] update_sec, last_period;
    logic [1:0]  state;
    logic [7:0]  lost_count;

    pps_source_ctrl #(
        .NOM_PERIOD(32'd1000),
        .SYSCLKTYPE("NONE")
    ) dut (
        .sys_clk_i      (clk),
        .sys_rst_n_i    (rst_n),
        .ctrl_en_i      (ctrl_en),
        .ext_edge_i     (ext_edge),
        .pps_flag_i     (pps_flag),
        .tol_i          (tol),
        .qual_count_i   (qual),
        .sec_load_req_i (req),
        .sec_load_val_i (val),
        .use_ext_pps_o  (use_ext),
        .en_int_pps_o   (en_int),
        .load_sec_o     (load_sec),
        .update_sec_o   (update_sec),
        .sec_load_busy_o(busy),
        .state_o        (state),
        .lost_count_o   (lost_count),
        .last_period_o  (last_period)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cyc;
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t q_state[$], q_ext[$], q_busy[$], q_load[$], q_en[$];

    function automatic exp_t mk(input int unsigned c, input logic [31:0] v,
                                input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.cyc = c; e.v = v; e.a = a; e.b = b;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected change to 0x%0h (cycle %0d)", name, act, cyc);
    endtask

    // reference model: values expected in the next cycle, and currently visible
    logic [1:0]  nx_state = '0, vs_state = '0;
    logic        nx_ext = 1'b0, vs_ext = 1'b0;
    logic        nx_busy = 1'b0, vs_busy = 1'b0;
    logic        nx_en = 1'b0, vs_en = 1'b0;
    logic        nx_load = 1'b0;
    logic [31:0] nx_load_val = '0;
    logic [31:0] nx_period = '0;
    logic [7:0]  nx_lost = '0;
    bit          m_armed = 1'b0;
    int unsigned m_last = 0;
    int unsigned m_gr = 0;
    int          m_pv = 0;          // verdict visible now: 0 none, 1 good, 2 bad, 3 miss
    bit          m_pend = 1'b0;
    logic [31:0] m_pval = '0;

    bit g_en = 1'b1;
    bit rl = 1'b0;

    task automatic step(input bit e, input bit rq, input logic [31:0] rv,
                        input bit fl, input bit en, input bit rn);
        int unsigned c;
        int          v;
        int unsigned p;
        int unsigned d;
        logic [1:0]  ns;
        @(posedge clk);
        #1;
        ext_edge = e; req = rq; val = rv; pps_flag = fl; ctrl_en = en; rst_n = rn;
        c = cyc;
        if (!rn) begin
            nx_state = '0; nx_ext = 1'b0; nx_busy = 1'b0; nx_en = 1'b0;
            nx_load = 1'b0; nx_period = '0; nx_lost = '0;
        end
        if (nx_state != vs_state)
            q_state.push_back(mk(c, 32'(nx_state), STATS ? 32'(nx_lost) : 32'd0,
                                 STATS ? nx_period : 32'd0));
        if (nx_ext != vs_ext)   q_ext.push_back(mk(c, 32'(nx_ext), 0, 0));
        if (nx_busy != vs_busy) q_busy.push_back(mk(c, 32'(nx_busy), 0, 0));
        if (nx_en != vs_en)     q_en.push_back(mk(c, 32'(nx_en), 0, 0));
        if (nx_load)            q_load.push_back(mk(c, nx_load_val, 0, 0));
        vs_state = nx_state; vs_ext = nx_ext; vs_busy = nx_busy; vs_en = nx_en;
        if (!rn) begin
            m_armed = 1'b0; m_gr = 0; m_pv = 0; m_pend = 1'b0;
            return;
        end

        nx_en  = 1'b1;
        nx_ext = (vs_state == 2'd2);

        v = 0;
        if (!en) begin
            m_armed = 1'b0;
        end else if (e) begin
            if (m_armed) begin
                p = c - m_last;
                d = (p > NOM) ? p - NOM : NOM - p;
                v = (d <= TOL) ? 1 : 2;
                nx_period = p;
            end
            m_armed = 1'b1;
            m_last  = c;
        end else if (m_armed && (c - m_last) == NOM + TOL + 1) begin
            v = 3;
            m_armed = 1'b0;
        end

        ns = vs_state;
        if (!en) begin
            ns = 2'd0; m_gr = 0;
        end else begin
            case (vs_state)
                2'd0: begin ns = 2'd1; m_gr = 0; end
                2'd1, 2'd3: begin
                    if (m_pv == 1) begin
                        m_gr++;
                        if (m_gr >= QUAL) begin ns = 2'd2; m_gr = 0; end
                    end else if (m_pv >= 2) m_gr = 0;
                end
                default: begin
                    if (m_pv >= 2) begin
                        ns = 2'd3; m_gr = 0;
                        if (nx_lost != 8'hFF) nx_lost++;
                    end
                end
            endcase
        end
        nx_state = ns;
        m_pv = v;

        nx_busy = rq || m_pend;
        nx_load = 1'b0;
        if (fl && (m_pend || rq)) begin
            nx_load     = 1'b1;
            nx_load_val = rq ? rv : m_pval;
            m_pend      = 1'b0;
        end else if (rq) begin
            m_pend = 1'b1;
            m_pval = rv;
        end
    endtask

    task automatic idle(input int unsigned n);
        bit          rq, fl;
        logic [31:0] rv;
        for (int unsigned i = 0; i < n; i++) begin
            rq = rl && ($urandom_range(0, 299) == 0);
            fl = rl && ($urandom_range(0, 249) == 0);
            rv = $urandom;
            step(1'b0, rq, rv, fl, g_en, 1'b1);
        end
    endtask

    task automatic period(input int unsigned p);
        idle(p - 1);
        step(1'b1, 1'b0, 32'd0, 1'b0, g_en, 1'b1);
    endtask

    task automatic rand_period();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       period(NOM - TOL + $urandom_range(0, 2 * TOL));
        else if (r == 7) period($urandom_range(900, NOM - TOL - 1));
        else             period($urandom_range(NOM + TOL + 1, 1300));
    endtask

    initial begin : monitor
        logic [1:0] p_state;
        logic       p_ext, p_busy, p_en;
        exp_t       e;
        p_state = '0; p_ext = 1'b0; p_busy = 1'b0; p_en = 1'b0;
        forever begin
            @(negedge clk);
            if (state !== p_state) begin
                if (q_state.size() == 0) unexpected("state", 32'(state));
                else begin
                    e = q_state.pop_front();
                    chk("state_cycle", cyc, e.cyc);
                    chk("state", 32'(state), e.v);
                    chk("lost_count", 32'(lost_count), e.a);
                    chk("last_period", last_period, e.b);
                end
                p_state = state;
            end
            if (use_ext !== p_ext) begin
                if (q_ext.size() == 0) unexpected("use_ext", 32'(use_ext));
                else begin
                    e = q_ext.pop_front();
                    chk("use_ext_cycle", cyc, e.cyc);
                    chk("use_ext", 32'(use_ext), e.v);
                end
                p_ext = use_ext;
            end
            if (busy !== p_busy) begin
                if (q_busy.size() == 0) unexpected("busy", 32'(busy));
                else begin
                    e = q_busy.pop_front();
                    chk("busy_cycle", cyc, e.cyc);
                    chk("busy", 32'(busy), e.v);
                end
                p_busy = busy;
            end
            if (en_int !== p_en) begin
                if (q_en.size() == 0) unexpected("en_int", 32'(en_int));
                else begin
                    e = q_en.pop_front();
                    chk("en_int_cycle", cyc, e.cyc);
                    chk("en_int", 32'(en_int), e.v);
                end
                p_en = en_int;
            end
            if (load_sec === 1'b1) begin
                if (q_load.size() == 0) unexpected("load_sec", update_sec);
                else begin
                    e = q_load.pop_front();
                    chk("load_cycle", cyc, e.cyc);
                    chk("update_sec", update_sec, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_use_ext", 32'(use_ext), 32'd0);
        chk("rst_en_int", 32'(en_int), 32'd0);
        chk("rst_load_sec", 32'(load_sec), 32'd0);
        chk("rst_update_sec", update_sec, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lost_count", 32'(lost_count), 32'd0);
        chk("rst_last_period", last_period, 32'd0);

        // lock from reset with exact periods, then a long period (miss) and relock
        repeat (5) period(NOM);
        period(1010);
        repeat (3) period(NOM);
        repeat (2) period(NOM - TOL + $urandom_range(0, 2 * TOL));
        period(990);
        repeat (3) period(NOM - TOL + $urandom_range(0, 2 * TOL));

        // edges stop: miss, then the next edge only arms
        idle(1500);
        step(1'b1, 1'b0, 32'd0, 1'b0, g_en, 1'b1);
        repeat (3) period(NOM);

        // randomized periods with background load traffic
        rl = 1'b1;
        repeat (12) rand_period();
        rl = 1'b0;
        idle(5);

        // last request wins
        step(1'b0, 1'b1, 32'h12345678, 1'b0, g_en, 1'b1);
        idle(5);
        step(1'b0, 1'b1, 32'h0000ABCD, 1'b0, g_en, 1'b1);
        idle(10);
        step(1'b0, 1'b0, 32'd0, 1'b1, g_en, 1'b1);
        idle(5);
        // request in the flag cycle
        step(1'b0, 1'b1, 32'hCAFE0001, 1'b1, g_en, 1'b1);
        idle(5);
        // request during the strobe cycle stays pending
        step(1'b0, 1'b1, 32'h00000011, 1'b0, g_en, 1'b1);
        idle(3);
        step(1'b0, 1'b0, 32'd0, 1'b1, g_en, 1'b1);
        step(1'b0, 1'b1, 32'h00000022, 1'b0, g_en, 1'b1);
        idle(3);
        step(1'b0, 1'b0, 32'd0, 1'b1, g_en, 1'b1);
        idle(3);

        // ctrl_en drop forces INT, then requalify
        repeat (5) period(NOM);
        g_en = 1'b0;
        idle(30);
        g_en = 1'b1;
        repeat (5) period(NOM);

        // reset with a load pending while LOCKED; pending load must be dropped
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, g_en, 1'b1);
        idle(3);
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle(20);
        step(1'b0, 1'b0, 32'd0, 1'b1, g_en, 1'b1);
        idle(10);
        repeat (5) period(NOM);
        idle(10);

        repeat (3) @(negedge clk);
        chk("pending_state", 32'(q_state.size()), 32'd0);
        chk("pending_use_ext", 32'(q_ext.size()), 32'd0);
        chk("pending_busy", 32'(q_busy.size()), 32'd0);
        chk("pending_en_int", 32'(q_en.size()), 32'd0);
        chk("pending_load", 32'(q_load.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
